// File: rtl/axis_patgen_pkg.sv
// Shared definitions for the AXI4-Stream pattern generator:
// data-mode encodings, FSM state constants and Galois LFSR tap masks.
package axis_patgen_pkg;

    // Payload selection, as driven on cfg_mode
    typedef enum logic [1:0] {
        MODE_CNT   = 2'd0,
        MODE_LFSR  = 2'd1,
        MODE_CONST = 2'd2,
        MODE_WALK  = 2'd3
    } patgen_mode_e;

    // Generator FSM states (IDLE / SEND / GAP)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Widest LFSR the tap helper can describe
    localparam int LFSR_MAX_W = 256;

    // Right-shifting Galois tap mask for a w-bit LFSR. The listed widths use
    // maximal-length polynomials; any other width falls back to the two top
    // bits, which still cycles but is not guaranteed to be maximal length.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_taps(input int w);
        logic [LFSR_MAX_W-1:0] t;
        t = '0;
        case (w)
            16:      t[15:0] = 16'hB400;
            24:      t[23:0] = 24'hE1_0000;
            32:      t[31:0] = 32'h8020_0003;
            64:      t[63:0] = 64'hD800_0000_0000_0000;
            default: begin
                t[w-1] = 1'b1;
                t[w-2] = 1'b1;
            end
        endcase
        return t;
    endfunction

endpackage

// File: rtl/axis_pattern_gen_if.sv
// AXI4-Stream bus bundle used between the pattern generator and its sink.
// DATA_W / USER_W must match the parameters of the generator it is bound to.
interface axis_pattern_gen_if #(
    parameter int DATA_W = 32,
    parameter int USER_W = 1
);
    localparam int KEEP_W = DATA_W / 8;

    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic [USER_W-1:0] tuser;

    modport master (output tvalid, tdata, tkeep, tlast, tuser, input  tready);
    modport slave  (input  tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/axis_patgen_lfsr.sv
// Galois LFSR (right-shifting) with synchronous seed load and advance enable.
// Load has priority over advance so a restart always begins at the seed.
module axis_patgen_lfsr
    import axis_patgen_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             i_load,
    input  logic             i_adv,
    output logic [WIDTH-1:0] o_state
);
    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_next;

    assign w_next  = (r_state >> 1) ^ (r_state[0] ? TAPS : '0);
    assign o_state = r_state;

    // Seed on reset/restart, step once per accepted beat
    always_ff @(posedge clk) begin
        if (srst || i_load) begin
            r_state <= SEED;
        end else if (i_adv) begin
            r_state <= w_next;
        end
    end
endmodule

// File: rtl/axis_pattern_gen.sv
// Configurable AXI4-Stream test-pattern source.
// Modes: counter {frame_id, beat_idx}, LFSR, constant, walking one.
// Run-time frame length, frame count, inter-frame gap, partial last-beat
// TKEEP, start/stop control and SOF on TUSER[0].
// Optional build macro AXIS_PATGEN_STALL_STATS_EN adds stall_cycles and
// max_stall backpressure statistics outputs.
// Payload is a pure function of registered state that only moves on a
// handshake, so it stays stable while the sink stalls.
module axis_pattern_gen
    import axis_patgen_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                KEEP_W    = DATA_W / 8,
    parameter int                USER_W    = 1,
    parameter int                LEN_W     = 16,
    parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'(32'hACE1_ACE1)
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    cfg_start,
    input  logic                    cfg_stop,
    input  logic [1:0]              cfg_mode,
    input  logic [LEN_W-1:0]        cfg_frame_beats,
    input  logic [LEN_W-1:0]        cfg_num_frames,
    input  logic [7:0]              cfg_gap_cycles,
    input  logic [$clog2(KEEP_W):0] cfg_last_keep_bytes,
    input  logic [DATA_W-1:0]       cfg_const,
    axis_pattern_gen_if.master      m_axis,
    output logic                    busy,
    output logic [LEN_W-1:0]        frames_done
`ifdef AXIS_PATGEN_STALL_STATS_EN
    ,
    output logic [31:0]             stall_cycles,
    output logic [15:0]             max_stall
`endif
);
    localparam int HALF_W = DATA_W / 2;
    localparam int KB_W   = $clog2(KEEP_W) + 1;

    logic [1:0]        r_state;
    patgen_mode_e      r_mode;
    logic [LEN_W-1:0]  r_frame_beats;
    logic [LEN_W-1:0]  r_num_frames;
    logic [LEN_W-1:0]  r_beat_idx;
    logic [LEN_W-1:0]  r_frames_done;
    logic [7:0]        r_gap_cycles;
    logic [7:0]        r_gap_cnt;
    logic [KEEP_W-1:0] r_last_keep;
    logic [DATA_W-1:0] r_const;
    logic [DATA_W-1:0] r_walk;
    logic              r_stop_pending;

    logic              w_start;
    logic              w_valid;
    logic              w_hs;
    logic              w_last_beat;
    logic              w_last_hs;
    logic              w_run_over;
    logic [KEEP_W-1:0] w_keep_lo;
    logic [DATA_W-1:0] w_lfsr;
    logic [DATA_W-1:0] w_data;
    logic [HALF_W-1:0] w_cnt_hi;
    logic [HALF_W-1:0] w_cnt_lo;

    // A stop arriving with start wins: the run is never begun
    assign w_start     = (r_state == ST_IDLE) && cfg_start && !cfg_stop;
    assign w_valid     = (r_state == ST_SEND);
    assign w_hs        = w_valid && m_axis.tready;
    assign w_last_beat = (r_beat_idx == r_frame_beats - 1'b1);
    assign w_last_hs   = w_hs && w_last_beat;
    // Run ends after this frame on a pending/arriving stop or the frame limit
    assign w_run_over  = r_stop_pending || cfg_stop ||
                         ((r_num_frames != '0) && (r_frames_done + 1'b1 == r_num_frames));

    // Last-beat byte mask: low N lanes, or all lanes for N==0 / N>KEEP_W
    generate
        for (genvar gi = 0; gi < KEEP_W; gi++) begin : g_keep
            assign w_keep_lo[gi] = (KB_W'(gi) < cfg_last_keep_bytes) ||
                                   (cfg_last_keep_bytes == '0) ||
                                   (cfg_last_keep_bytes > KB_W'(KEEP_W));
        end
    endgenerate

    axis_patgen_lfsr #(
        .WIDTH (DATA_W),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk     (aclk),
        .srst    (areset),
        .i_load  (w_start),
        .i_adv   (w_hs),
        .o_state (w_lfsr)
    );

    assign w_cnt_hi = HALF_W'(r_frames_done);
    assign w_cnt_lo = HALF_W'(r_beat_idx);

    // Payload selection for the currently presented beat
    always_comb begin
        w_data = '0;
        case (r_mode)
            MODE_CNT:   w_data = {w_cnt_hi, w_cnt_lo};
            MODE_LFSR:  w_data = w_lfsr;
            MODE_CONST: w_data = r_const;
            MODE_WALK:  w_data = r_walk;
            default:    w_data = '0;
        endcase
    end

    assign m_axis.tvalid = w_valid;
    assign m_axis.tdata  = w_valid ? w_data : '0;
    assign m_axis.tlast  = w_valid && w_last_beat;
    assign m_axis.tkeep  = (w_valid && w_last_beat) ? r_last_keep : '1;
    assign m_axis.tuser  = USER_W'(w_valid && (r_beat_idx == '0));
    assign busy          = (r_state != ST_IDLE);
    assign frames_done   = r_frames_done;

    // Run control FSM: frame sequencing, inter-frame gap and stop handling
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state        <= ST_IDLE;
            r_stop_pending <= 1'b0;
            r_gap_cnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_stop_pending <= 1'b0;
                    if (w_start) begin
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (cfg_stop) begin
                        r_stop_pending <= 1'b1;
                    end
                    if (w_last_hs) begin
                        if (w_run_over) begin
                            r_state        <= ST_IDLE;
                            r_stop_pending <= 1'b0;
                        end else if (r_gap_cycles != '0) begin
                            r_state   <= ST_GAP;
                            r_gap_cnt <= r_gap_cycles;
                        end
                    end
                end
                ST_GAP: begin
                    r_gap_cnt <= r_gap_cnt - 8'd1;
                    if (cfg_stop || r_stop_pending) begin
                        r_state        <= ST_IDLE;
                        r_stop_pending <= 1'b0;
                    end else if (r_gap_cnt == 8'd1) begin
                        r_state <= ST_SEND;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Config capture at start, beat/frame counters and walking-one advance
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_mode        <= MODE_CNT;
            r_frame_beats <= LEN_W'(1);
            r_num_frames  <= '0;
            r_gap_cycles  <= '0;
            r_last_keep   <= '1;
            r_const       <= '0;
            r_beat_idx    <= '0;
            r_frames_done <= '0;
            r_walk        <= DATA_W'(1);
        end else if (w_start) begin
            r_mode        <= patgen_mode_e'(cfg_mode);
            r_frame_beats <= (cfg_frame_beats == '0) ? LEN_W'(1) : cfg_frame_beats;
            r_num_frames  <= cfg_num_frames;
            r_gap_cycles  <= cfg_gap_cycles;
            r_last_keep   <= w_keep_lo;
            r_const       <= cfg_const;
            r_beat_idx    <= '0;
            r_frames_done <= '0;
            r_walk        <= DATA_W'(1);
        end else if (w_hs) begin
            if (w_last_beat) begin
                r_beat_idx    <= '0;
                r_frames_done <= r_frames_done + 1'b1;
                r_walk        <= DATA_W'(1);
            end else begin
                r_beat_idx    <= r_beat_idx + 1'b1;
                r_walk        <= {r_walk[DATA_W-2:0], r_walk[DATA_W-1]};
            end
        end
    end

`ifdef AXIS_PATGEN_STALL_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [15:0] r_cur_stall;
    logic [15:0] r_max_stall;
    logic        w_stall;
    logic [15:0] w_cur_inc;

    assign w_stall      = w_valid && !m_axis.tready;
    assign w_cur_inc    = (r_cur_stall == 16'hFFFF) ? r_cur_stall : r_cur_stall + 16'd1;
    assign stall_cycles = r_stall_cycles;
    assign max_stall    = r_max_stall;

    // Backpressure statistics: total stalled cycles and longest stall run
    always_ff @(posedge aclk) begin
        if (areset || w_start) begin
            r_stall_cycles <= '0;
            r_cur_stall    <= '0;
            r_max_stall    <= '0;
        end else if (w_stall) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
            r_cur_stall    <= w_cur_inc;
            if (w_cur_inc > r_max_stall) begin
                r_max_stall <= w_cur_inc;
            end
        end else begin
            r_cur_stall <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Self-checking bench for axis_pattern_gen: a frame-level reference model
// builds the expected beat list for each run, and a negedge monitor compares
// every accepted beat, stall stability and inter-frame gap lengths.
module tb_axis_pattern_gen;
    import axis_patgen_pkg::*;

    localparam logic [31:0] SEED = 32'hACE1_ACE1;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        sof;
    } beat_t;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        cfg_start = 1'b0;
    logic        cfg_stop = 1'b0;
    logic [1:0]  cfg_mode = '0;
    logic [15:0] cfg_frame_beats = '0;
    logic [15:0] cfg_num_frames = '0;
    logic [7:0]  cfg_gap_cycles = '0;
    logic [2:0]  cfg_last_keep_bytes = '0;
    logic [31:0] cfg_const = '0;
    logic        busy;
    logic [15:0] frames_done;
`ifdef AXIS_PATGEN_STALL_STATS_EN
    logic [31:0] stall_cycles;
    logic [15:0] max_stall;
`endif

    axis_pattern_gen_if #(.DATA_W(32), .USER_W(1)) axis ();

    axis_pattern_gen dut (
        .aclk                (aclk),
        .areset              (areset),
        .cfg_start           (cfg_start),
        .cfg_stop            (cfg_stop),
        .cfg_mode            (cfg_mode),
        .cfg_frame_beats     (cfg_frame_beats),
        .cfg_num_frames      (cfg_num_frames),
        .cfg_gap_cycles      (cfg_gap_cycles),
        .cfg_last_keep_bytes (cfg_last_keep_bytes),
        .cfg_const           (cfg_const),
        .m_axis              (axis),
        .busy                (busy),
        .frames_done         (frames_done)
`ifdef AXIS_PATGEN_STALL_STATS_EN
        ,
        .stall_cycles        (stall_cycles),
        .max_stall           (max_stall)
`endif
    );

    initial forever #5 aclk = ~aclk;

    int    total = 0;
    int    bad = 0;
    int    ready_pct = 100;
    int    exp_gap = 0;
    beat_t exp_arr[$];

    // Monitor-owned state
    int          rd_idx = 0;
    int          idle_cnt = 0;
    logic        gap_armed = 1'b0;
    logic        prev_stall = 1'b0;
    logic [37:0] prev_payload = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] taps;
        taps = 32'(lfsr_taps(32));
        return (s >> 1) ^ (s[0] ? taps : 32'h0);
    endfunction

    function automatic logic [3:0] keep_of(input int kb);
        if (kb == 0 || kb > 4) return 4'hF;
        return 4'((1 << kb) - 1);
    endfunction

    task automatic build(input int mode, input int beats, input int frames,
                         input int kb, input logic [31:0] cst);
        logic [31:0] lf;
        int          nb;
        beat_t       b;
        exp_arr.delete();
        lf = SEED;
        nb = (beats == 0) ? 1 : beats;
        for (int f = 0; f < frames; f++) begin
            for (int i = 0; i < nb; i++) begin
                case (mode)
                    0:       b.data = {f[15:0], i[15:0]};
                    1:       b.data = lf;
                    2:       b.data = cst;
                    default: b.data = 32'd1 << (i % 32);
                endcase
                b.last = (i == nb - 1);
                b.sof  = (i == 0);
                b.keep = b.last ? keep_of(kb) : 4'hF;
                lf = lfsr_step(lf);
                exp_arr.push_back(b);
            end
        end
    endtask

    // ---------------- sink ready generator ----------------
    initial begin
        axis.tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            axis.tready = ($urandom_range(99) < ready_pct);
        end
    end

    // ---------------- compare process ----------------
    always @(negedge aclk) begin
        if (areset) begin
            rd_idx     = 0;
            prev_stall = 1'b0;
            gap_armed  = 1'b0;
        end else begin
            if (cfg_start && !busy) begin
                rd_idx    = 0;
                gap_armed = 1'b0;
            end
            if (axis.tvalid) begin
                if (gap_armed) begin
                    check("gap_len", 64'(idle_cnt), 64'(exp_gap));
                    gap_armed = 1'b0;
                end
                if (prev_stall)
                    check("stall_hold", {axis.tdata, axis.tkeep, axis.tlast, axis.tuser[0]}, prev_payload);
                if (axis.tready) begin
                    if (rd_idx < exp_arr.size()) begin
                        check("tdata", axis.tdata, exp_arr[rd_idx].data);
                        check("tkeep", axis.tkeep, exp_arr[rd_idx].keep);
                        check("tlast", axis.tlast, exp_arr[rd_idx].last);
                        check("tuser_sof", axis.tuser, exp_arr[rd_idx].sof);
                    end else begin
                        check("extra_beat", 64'(rd_idx), 64'(exp_arr.size()));
                    end
                    rd_idx++;
                    if (axis.tlast) begin
                        gap_armed = 1'b1;
                        idle_cnt  = 0;
                    end
                    prev_stall = 1'b0;
                end else begin
                    prev_stall   = 1'b1;
                    prev_payload = {axis.tdata, axis.tkeep, axis.tlast, axis.tuser[0]};
                end
            end else begin
                if (prev_stall) check("valid_dropped", 0, 1);
                prev_stall = 1'b0;
                if (gap_armed) idle_cnt++;
            end
            if (!busy) gap_armed = 1'b0;
        end
    end

    // ---------------- run helpers ----------------
    task automatic start_run(input int mode, input int beats, input int frames, input int gap,
                             input int kb, input logic [31:0] cst, input int pct,
                             input int gen_frames);
        build(mode, beats, gen_frames, kb, cst);
        exp_gap   = gap;
        ready_pct = pct;
        @(posedge aclk); #1;
        cfg_mode            = 2'(mode);
        cfg_frame_beats     = 16'(beats);
        cfg_num_frames      = 16'(frames);
        cfg_gap_cycles      = 8'(gap);
        cfg_last_keep_bytes = 3'(kb);
        cfg_const           = cst;
        cfg_start           = 1'b1;
        @(posedge aclk); #1;
        cfg_start = 1'b0;
        check("valid_after_start", axis.tvalid, 1);
        check("busy_after_start", busy, 1);
        // Config changes and a second start while busy must be ignored
        cfg_mode            = 2'($urandom);
        cfg_frame_beats     = 16'($urandom_range(1, 9));
        cfg_num_frames      = 16'($urandom_range(1, 9));
        cfg_gap_cycles      = 8'($urandom_range(0, 9));
        cfg_last_keep_bytes = 3'($urandom);
        cfg_const           = $urandom;
        cfg_start           = busy;
        @(posedge aclk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic finish_run(input int exp_frames);
        int cyc = 0;
        while (busy && cyc < 4000) begin
            @(negedge aclk);
            cyc++;
        end
        check("run_ends", busy, 0);
        check("beat_count", 64'(rd_idx), 64'(exp_arr.size()));
        check("frames_done", frames_done, 64'(exp_frames & 16'hFFFF));
        check("idle_tvalid", axis.tvalid, 0);
    endtask

    task automatic wait_frames(input int n);
        int cyc = 0;
        while (frames_done != 16'(n) && cyc < 4000) begin
            @(negedge aclk);
            cyc++;
        end
        check("reach_frame", frames_done, 64'(n));
    endtask

    task automatic pulse_stop();
        @(posedge aclk); #1;
        cfg_stop = 1'b1;
        @(posedge aclk); #1;
        cfg_stop = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        check("rst_tvalid", axis.tvalid, 0);
        check("rst_tdata", axis.tdata, 0);
        check("rst_tkeep", axis.tkeep, 4'hF);
        check("rst_tlast", axis.tlast, 0);
        check("rst_tuser", axis.tuser, 0);
        check("rst_busy", busy, 0);
        check("rst_frames_done", frames_done, 0);

        // Counter mode, 2 frames x 4 beats, full rate
        start_run(0, 4, 2, 0, 0, 32'h0, 100, 2);
        finish_run(2);
        check("pin_cnt_b5", exp_arr[5].data, 32'h0001_0001);
        check("pin_cnt_b7", exp_arr[7].data, 32'h0001_0003);
        check("pin_last_b3", exp_arr[3].last, 1);
        check("pin_sof_b4", exp_arr[4].sof, 1);

        // Same sequence under random backpressure
        start_run(0, 4, 2, 0, 0, 32'h0, 50, 2);
        finish_run(2);

        // LFSR mode with a 3-cycle gap
        start_run(1, 2, 4, 3, 0, 32'h0, 70, 4);
        finish_run(4);
        check("pin_lfsr_0", exp_arr[0].data, 32'hACE1_ACE1);
        check("pin_lfsr_1", exp_arr[1].data, 32'hD650_D673);

        // Walking one across more beats than bits, 1-byte last beat
        start_run(3, 40, 2, 1, 1, 32'h0, 80, 2);
        finish_run(2);
        check("pin_walk_33", exp_arr[33].data, 32'h0000_0002);
        check("pin_keep1", exp_arr[39].keep, 4'b0001);

        // Constant mode, single-beat frames, 3-byte last beat
        start_run(2, 1, 3, 2, 3, 32'hDEAD_BEEF, 60, 3);
        finish_run(3);
        check("pin_keep3", exp_arr[0].keep, 4'b0111);

        // frame_beats=0 treated as 1, oversized keep count means all bytes
        start_run(0, 0, 2, 0, 7, 32'h0, 100, 2);
        finish_run(2);

        // Unlimited run, stop during frame 5 -> 6 frames complete
        start_run(0, 4, 0, 0, 0, 32'h0, 60, 6);
        wait_frames(5);
        pulse_stop();
        finish_run(6);

        // Stop while in the inter-frame gap -> idle next cycle
        start_run(0, 2, 0, 6, 0, 32'h0, 100, 2);
        wait_frames(2);
        pulse_stop();
        check("gap_stop_busy", busy, 0);
        finish_run(2);

        // Start and stop together in IDLE -> start ignored
        @(posedge aclk); #1;
        cfg_start = 1'b1;
        cfg_stop  = 1'b1;
        @(posedge aclk); #1;
        cfg_start = 1'b0;
        cfg_stop  = 1'b0;
        check("start_stop_busy", busy, 0);
        check("start_stop_tvalid", axis.tvalid, 0);

        // Reset mid-frame while stalled, then restart LFSR from seed
        start_run(1, 8, 1, 0, 0, 32'h0, 100, 1);
        ready_pct = 0;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        check("abort_tvalid", axis.tvalid, 0);
        check("abort_tkeep", axis.tkeep, 4'hF);
        check("abort_tlast", axis.tlast, 0);
        check("abort_busy", busy, 0);
        check("abort_frames_done", frames_done, 0);
        start_run(1, 4, 2, 0, 0, 32'h0, 100, 2);
        finish_run(2);

        // Randomized configurations
        for (int r = 0; r < 8; r++) begin
            int md, bt, fr, gp, kb, pc;
            md = $urandom_range(0, 3);
            bt = $urandom_range(0, 6);
            fr = $urandom_range(1, 4);
            gp = $urandom_range(0, 4);
            kb = $urandom_range(0, 7);
            pc = $urandom_range(30, 100);
            start_run(md, bt, fr, gp, kb, $urandom, pc, fr);
            finish_run(fr);
        end

        repeat (3) @(posedge aclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

endmodule
